four_bit_subtractor: RTL and testbench

//  Registered unsigned subtractor: computes diff = X - Y and borrow-out each clock.

---
 rtl/four_bit_subtractor_pkg.sv | 13 +
 rtl/four_bit_subtractor_if.sv | 28 ++
 rtl/full_subtractor.sv | 15 +
 rtl/four_bit_subtractor.sv | 47 ++++
 tb/tb_four_bit_subtractor.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/four_bit_subtractor_pkg.sv
// Shared constants for the subtractor slice of the ALU datapath.
// DATA_WIDTH is the default operand width for the subtractor and its bus.
package four_bit_subtractor_pkg;

  localparam int DATA_WIDTH = 4;

  // Registered result as seen on the bus: borrow above the difference bits.
  typedef struct packed {
    logic                  borrow;
    logic [DATA_WIDTH-1:0] diff;
  } sub_result_t;

endpackage : four_bit_subtractor_pkg

// File: rtl/four_bit_subtractor_if.sv
// Operand/result bus of the subtractor. The master drives X/Y; the slave returns diff/borrow.
// Free-running: no valid/ready. Every rising clk samples X/Y, and the result is presented one edge later.
interface four_bit_subtractor_if
  import four_bit_subtractor_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
);

  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output X,
    output Y,
    input  diff,
    input  borrow
  );

  modport slave (
    input  X,
    input  Y,
    output diff,
    output borrow
  );

endinterface : four_bit_subtractor_if

// File: rtl/full_subtractor.sv
// One-bit full subtractor computing x - y - bin, with borrow-out.
// This cell is purely combinational and is chained LSB to MSB by the top.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow occurs when y exceeds x, or when the bits tie and a borrow is already pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/four_bit_subtractor.sv
// Registered unsigned subtractor: diff = (X - Y) mod 2^WIDTH, borrow = (X < Y).
// A ripple chain of full_subtractor cells feeds one output register with a synchronous reset.
module four_bit_subtractor
  import four_bit_subtractor_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  four_bit_subtractor_if.slave bus
);

  logic [WIDTH:0]   borrow_chain;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_d;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  assign borrow_chain[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_subtractor u_fs (
      .x    (bus.X[i]),
      .y    (bus.Y[i]),
      .bin  (borrow_chain[i]),
      .d    (diff_d[i]),
      .bout (borrow_chain[i+1])
    );
  end

  assign borrow_d = borrow_chain[WIDTH];

  // Reset drops the operands sampled on that edge; results resume on the first edge with rst_n high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule : four_bit_subtractor

// File: tb/tb_four_bit_subtractor.sv
// Bench for four_bit_subtractor: reset, directed table, back-to-back, random and exhaustive sweeps.
// Results are checked against an arithmetic model computed as X - Y on plain integers.
module tb_four_bit_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] diff;
    logic         borrow;
  } vec_t;

  logic clk;
  logic rst_n;

  four_bit_subtractor_if #(.WIDTH(W)) bus ();

  four_bit_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W:0] exp_q[$];
  logic [W:0] last_exp;
  bit         have_last;
  int         passed;
  int         total;

  // Reference model: unsigned subtraction on integers, wrapped into W bits.
  function automatic logic [W:0] ref_sub(input int x, input int y);
    int         r;
    logic [W-1:0] d;
    logic         b;
    r = x - y;
    if (r < 0) begin
      r = r + (1 << W);
    end
    d = r[W-1:0];
    b = (x < y);
    return {b, d};
  endfunction

  task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got diff=%b borrow=%b, expected diff=%b borrow=%b",
               name, got[W-1:0], got[W], exp[W-1:0], exp[W]);
    end
  endtask

  // Driver: apply one operand pair (or reset) for one edge, then check the result just after the edge.
  task automatic step(input logic [W-1:0] x, input logic [W-1:0] y, input logic rst,
                      input logic [W:0] exp, input string name);
    logic [W:0] got;
    logic [W:0] want;
    @(negedge clk);
    if (have_last) begin
      check({name, "_hold"}, {bus.borrow, bus.diff}, last_exp);
    end
    bus.X = x;
    bus.Y = y;
    rst_n = rst;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    got  = {bus.borrow, bus.diff};
    want = exp_q.pop_front();
    check(name, got, want);
    last_exp  = want;
    have_last = 1'b1;
  endtask

  vec_t vecs[9];

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    passed    = 0;
    total     = 0;
    have_last = 1'b0;
    last_exp  = '0;
    rst_n     = 1'b0;
    bus.X     = '0;
    bus.Y     = '0;

    vecs[0] = '{x: 4'd2,  y: 4'd1,  diff: 4'b0001, borrow: 1'b0};
    vecs[1] = '{x: 4'd6,  y: 4'd4,  diff: 4'b0010, borrow: 1'b0};
    vecs[2] = '{x: 4'd15, y: 4'd7,  diff: 4'b1000, borrow: 1'b0};
    vecs[3] = '{x: 4'd0,  y: 4'd8,  diff: 4'b1000, borrow: 1'b1};
    vecs[4] = '{x: 4'd5,  y: 4'd10, diff: 4'b1011, borrow: 1'b1};
    vecs[5] = '{x: 4'd0,  y: 4'd15, diff: 4'b0001, borrow: 1'b1};
    vecs[6] = '{x: 4'd9,  y: 4'd9,  diff: 4'b0000, borrow: 1'b0};
    vecs[7] = '{x: 4'd15, y: 4'd0,  diff: 4'b1111, borrow: 1'b0};
    vecs[8] = '{x: 4'd0,  y: 4'd0,  diff: 4'b0000, borrow: 1'b0};

    // Reset held for two edges with live operands, then released.
    step(4'd15, 4'd3, 1'b0, 5'b0_0000, "reset_edge0");
    step(4'd15, 4'd3, 1'b0, 5'b0_0000, "reset_edge1");
    step(4'd15, 4'd3, 1'b1, 5'b0_1100, "reset_release");

    // Directed table
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].x, vecs[i].y, 1'b1, {vecs[i].borrow, vecs[i].diff},
           $sformatf("table%0d_%0d_minus_%0d", i, vecs[i].x, vecs[i].y));
    end

    // Back-to-back: a new pair every cycle; each result must land exactly one edge later.
    for (int i = 0; i < 8; i++) begin
      rx = W'($urandom_range(0, 15));
      ry = W'($urandom_range(0, 15));
      step(rx, ry, 1'b1, ref_sub(int'(rx), int'(ry)), $sformatf("b2b%0d", i));
    end

    // Random stimulus
    for (int i = 0; i < 200; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      step(rx, ry, 1'b1, ref_sub(int'(rx), int'(ry)), $sformatf("rand%0d", i));
    end

    // Exhaustive sweep with a one-edge reset injected mid-sweep
    for (int i = 0; i < 256; i++) begin
      rx = W'(i >> 4);
      ry = W'(i & 15);
      if (i == 100) begin
        step(rx, ry, 1'b0, 5'b0_0000, "sweep_mid_reset");
      end
      step(rx, ry, 1'b1, ref_sub(int'(rx), int'(ry)), $sformatf("sweep_%0d_minus_%0d", rx, ry));
    end

    // Final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_four_bit_subtractor
